// File: rtl/eth_tx_fcs_ctrl.sv
// Ethernet transmit frame sequencer: forwards frame bytes, drives a byte-wide CRC-32 engine, appends the FCS LSB-first and enforces the inter-frame gap.
// Optional zero-padding of short frames is built when the macro TX_PAD_EN is defined.
module eth_tx_fcs_ctrl #(
   parameter int DATALEN    = 8,
   parameter int CRC_LEN    = 32,
   parameter int MIN_FRAME  = 60,
   parameter int MAX_FRAME  = 1514,
   parameter int IFG_CYCLES = 12,
   parameter int CNT_W      = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATALEN-1:0] s_data,
   input  logic               s_valid,
   input  logic               s_last,
   output logic               s_ready,
   output logic [DATALEN-1:0] m_data,
   output logic               m_valid,
   output logic               m_last,
   input  logic               m_ready,
   output logic               crc_init,
   output logic               crc_update,
   output logic [DATALEN-1:0] crc_data,
   input  logic [CRC_LEN-1:0] crc_result,
   output logic               busy,
   output logic               frame_done,
   output logic               err_oversize
);

   localparam int FCS_BYTES = CRC_LEN / DATALEN;
   localparam int IDX_W     = (FCS_BYTES > 1) ? $clog2(FCS_BYTES) : 1;
   localparam int IFG_W     = $clog2(IFG_CYCLES + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FCS_BYTES - 1);
   localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(MAX_FRAME + 1);
`ifdef TX_PAD_EN
   localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_FRAME);
`endif

   if (MIN_FRAME > MAX_FRAME || MAX_FRAME + 1 >= 2**CNT_W) begin : g_cfg_err
      $error("eth_tx_fcs_ctrl: frame length parameters do not fit the byte counter");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef TX_PAD_EN
      S_PAD,
`endif
      S_WAIT,
      S_FCS,
      S_IFG
   } state_t;

   state_t                               r_state;
   state_t                               w_next;
   logic [CNT_W-1:0]                     r_byte_cnt;
   logic [CNT_W-1:0]                     w_cnt_inc;
   logic                                 w_cnt_en;
   logic [CRC_LEN-1:0]                   r_fcs;
   logic [FCS_BYTES-1:0][DATALEN-1:0]    w_fcs_bytes;
   logic [IDX_W-1:0]                     r_idx;
   logic [IFG_W-1:0]                     r_ifg_cnt;
   logic                                 r_err;

   // Byte counter saturates rather than wrapping so an oversize frame can never look short.
   assign w_cnt_inc    = (&r_byte_cnt) ? r_byte_cnt : r_byte_cnt + 1'b1;
   assign w_fcs_bytes  = r_fcs;
   assign busy         = (r_state != S_IDLE);
   assign err_oversize = r_err;

   // NOTE: every output and w_next gets a default first, so no path can infer a latch.
   always_comb begin
      w_next     = r_state;
      s_ready    = 1'b0;
      m_data     = '0;
      m_valid    = 1'b0;
      m_last     = 1'b0;
      crc_init   = 1'b0;
      crc_update = 1'b0;
      crc_data   = '0;
      frame_done = 1'b0;
      w_cnt_en   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (s_valid) w_next = S_START;
         end
         S_START: begin
            crc_init = 1'b1;
            w_next   = S_DATA;
         end
         S_DATA: begin
            m_data     = s_data;
            m_valid    = s_valid;
            s_ready    = m_ready;
            crc_data   = s_data;
            crc_update = s_valid && m_ready;
            w_cnt_en   = s_valid && m_ready;
            if (s_valid && m_ready && s_last) begin
`ifdef TX_PAD_EN
               w_next = (w_cnt_inc < CNT_MIN) ? S_PAD : S_WAIT;
`else
               w_next = S_WAIT;
`endif
            end
         end
`ifdef TX_PAD_EN
         S_PAD: begin
            m_valid    = 1'b1;
            crc_update = m_ready;
            w_cnt_en   = m_ready;
            if (m_ready && w_cnt_inc == CNT_MIN) w_next = S_WAIT;
         end
`endif
         S_WAIT: begin
            // Engine result settles one cycle after its last update.
            w_next = S_FCS;
         end
         S_FCS: begin
            m_valid = 1'b1;
            m_data  = w_fcs_bytes[r_idx];
            m_last  = (r_idx == IDX_LAST);
            if (m_ready && r_idx == IDX_LAST) begin
               frame_done = 1'b1;
               w_next     = S_IFG;
            end
         end
         S_IFG: begin
            if (r_ifg_cnt == IFG_LAST) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: reset is synchronous and covers every register; there is no memory array here.
   // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_byte_cnt <= '0;
         r_fcs      <= '0;
         r_idx      <= '0;
         r_ifg_cnt  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_START) begin
            r_byte_cnt <= '0;
            r_err      <= 1'b0;
         end else if (w_cnt_en) begin
            r_byte_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_OVF) r_err <= 1'b1;
         end
         if (r_state == S_WAIT) begin
            r_fcs <= crc_result;
            r_idx <= '0;
         end else if (r_state == S_FCS && m_ready) begin
            r_idx <= r_idx + 1'b1;
         end
         r_ifg_cnt <= (r_state == S_IFG) ? r_ifg_cnt + 1'b1 : '0;
      end
   end

endmodule
